// File: rtl/output_collector.sv
// Collects column-skewed systolic results into a ROWS x COLS tile (overwrite or
// accumulate) and drains it as row-aligned vectors over valid/ready.
module output_collector #(
    parameter int COLS = 4,
    parameter int ROWS = 4,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               acc_mode,
    input  logic               drain,
    input  logic [COLS*DW-1:0] in_res,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COLS*DW-1:0] out_data,
    output logic               out_last,
    output logic               busy
);
    localparam int CW     = $clog2(ROWS + COLS);
    localparam int PW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LAST_T = ROWS + COLS - 2;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   t_q, t_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            acc_q, acc_d;
    logic            drn_q, drn_d;
    logic [DW-1:0]   mem_q [ROWS][COLS];
    logic [DW-1:0]   mem_d [ROWS][COLS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            ptr_q   <= '0;
            acc_q   <= 1'b0;
            drn_q   <= 1'b0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mem_q[r][c] <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            ptr_q   <= ptr_d;
            acc_q   <= acc_d;
            drn_q   <= drn_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        ptr_d   = ptr_q;
        acc_d   = acc_q;
        drn_d   = drn_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = acc_mode;
                    drn_d   = drain;
                    t_d     = '0;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                t_d = t_q + 1'b1;
                if (t_q == CW'(LAST_T)) begin
                    t_d     = '0;
                    ptr_d   = '0;
                    state_d = drn_q ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (ptr_q == PW'(ROWS - 1)) begin
                        ptr_d   = '0;
                        state_d = IDLE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane c lands in row t-c; each element sees exactly one write per tile.
    always_comb begin
        mem_d = mem_q;
        if (state_q == CAPTURE) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (int'(t_q) == r + c) begin
                        if (acc_q)
                            mem_d[r][c] = mem_q[r][c] + in_res[c*DW +: DW];
                        else
                            mem_d[r][c] = in_res[c*DW +: DW];
                    end
                end
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        assign out_data[c*DW +: DW] = (state_q == DRAIN) ? mem_q[ptr_q][c] : '0;
    end

    assign out_valid = (state_q == DRAIN);
    assign out_last  = (state_q == DRAIN) && (ptr_q == PW'(ROWS - 1));
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_output_collector.sv
// Scoreboard bench for output_collector: expected rows are queued when a tile
// is driven and popped on each output handshake.
module tb_output_collector;
    localparam int COLS = 4;
    localparam int ROWS = 4;
    localparam int DW   = 32;
    localparam int W    = COLS * DW + 1;
    typedef logic [W-1:0] w_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               acc_mode = 1'b0;
    logic               drain = 1'b0;
    logic [COLS*DW-1:0] in_res = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [COLS*DW-1:0] out_data;
    logic               out_last;
    logic               busy;

    int n_chk  = 0;
    int n_fail = 0;
    w_t sb [$];
    logic [DW-1:0] model [ROWS][COLS];

    output_collector #(.COLS(COLS), .ROWS(ROWS), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .drain(drain),
        .in_res(in_res), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input w_t got, input w_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] val(int kind, logic [DW-1:0] k, int r, int c);
        return (kind == 0) ? DW'(16 * r + c) : k;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("row_extra", w_t'(out_valid), 0);
                else chk("row", {out_last, out_data}, sb.pop_front());
            end else if (out_valid) begin
                if (sb.size() > 0) chk("hold", {out_last, out_data}, sb[0]);
            end else begin
                chk("idle_out", {out_last, out_data}, 0);
            end
        end
    end

    // Drives one tile: skewed lane data inside windows, junk outside them.
    task automatic run_tile(input logic acc, input logic drn, input int kind,
                            input logic [DW-1:0] k, input bit pls, input bit bp);
        int cyc;
        w_t row;
        chk("pre_busy", w_t'(busy), 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model[r][c] = acc ? model[r][c] + val(kind, k, r, c) : val(kind, k, r, c);
        if (drn) begin
            for (int r = 0; r < ROWS; r++) begin
                row = '0;
                row[COLS*DW] = (r == ROWS - 1);
                for (int c = 0; c < COLS; c++) row[c*DW +: DW] = model[r][c];
                sb.push_back(row);
            end
        end
        start = 1'b1; acc_mode = acc; drain = drn;
        tick();
        start = 1'b0; acc_mode = ~acc; drain = ~drn;
        for (int t = 0; t <= ROWS + COLS - 2; t++) begin
            for (int c = 0; c < COLS; c++)
                in_res[c*DW +: DW] = (t >= c && t < c + ROWS) ? val(kind, k, t - c, c) : 32'hDEADBEEF;
            start = pls && (t == 2);
            chk("cap_busy", w_t'(busy), 1);
            chk("cap_noval", w_t'(out_valid), 0);
            tick();
        end
        start = 1'b0;
        in_res = {COLS{32'hDEADBEEF}};
        if (drn) begin
            chk("lat_valid", w_t'(out_valid), 1);
            cyc = 0;
            for (int n = 0; busy && n < 40; n++) begin
                out_ready = !(bp && n >= 1 && n <= 3);
                start = pls && (n == 1);
                tick();
                cyc++;
            end
            start = 1'b0; out_ready = 1'b1;
            chk("drain_len", w_t'(cyc), bp ? ROWS + 3 : ROWS);
        end else begin
            chk("nodrain_val", w_t'(out_valid), 0);
        end
        chk("end_busy", w_t'(busy), 0);
        tick();
        chk("no_requeue", w_t'(busy), 0);
        chk("sb_empty", w_t'(sb.size()), 0);
    endtask

    initial begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) model[r][c] = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", w_t'(busy), 0);
        chk("rst_valid", w_t'(out_valid), 0);
        chk("rst_last", w_t'(out_last), 0);
        chk("rst_data", w_t'(out_data), 0);
        tick();

        run_tile(1'b0, 1'b1, 0, '0, 1'b0, 1'b0);              // overwrite + drain
        run_tile(1'b0, 1'b1, 0, '0, 1'b0, 1'b1);              // backpressure on row 1
        run_tile(1'b0, 1'b0, 1, 32'd1, 1'b0, 1'b0);           // tile A, held
        run_tile(1'b1, 1'b1, 1, 32'd2, 1'b0, 1'b0);           // accumulate -> 3
        run_tile(1'b0, 1'b0, 1, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_tile(1'b1, 1'b1, 1, 32'd2, 1'b0, 1'b0);           // wraps to 1
        run_tile(1'b0, 1'b1, 0, '0, 1'b1, 1'b0);              // stray starts

        // Reset at t=3 of a capture, then accumulate onto the cleared tile.
        start = 1'b1; acc_mode = 1'b1; drain = 1'b1;
        tick();
        start = 1'b0;
        in_res = {COLS{32'd7}};
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", w_t'(busy), 0);
        chk("mid_rst_valid", w_t'(out_valid), 0);
        chk("mid_rst_data", w_t'(out_data), 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) model[r][c] = '0;
        tick();
        run_tile(1'b1, 1'b1, 1, 32'd5, 1'b0, 1'b0);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
